// File: rtl/store_queue.sv
// store_queue: byte-masked circular store FIFO with youngest-first per-byte load forwarding and a ready/valid commit port
module store_queue #(
  parameter int N_LINES = 4,
  parameter int VA_WIDTH = 32,
  parameter int REG_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_is_store,
  input  logic                   i_is_load,
  input  logic [1:0]             i_size,
  input  logic [VA_WIDTH-1:0]    i_addr,
  input  logic [REG_WIDTH-1:0]   i_write_data,
  output logic                   o_hit,
  output logic [REG_WIDTH-1:0]   o_read_data,
  output logic                   o_stall,
  output logic                   o_exeption,
  output logic                   o_commit_valid,
  output logic [VA_WIDTH-1:0]    o_commit_addr,
  output logic [REG_WIDTH-1:0]   o_commit_data,
  output logic [REG_WIDTH/8-1:0] o_commit_mask,
  input  logic                   i_commit_ready,
  output logic                   o_empty
);
  localparam int N_BYTES = REG_WIDTH / 8;
  localparam int OFF_WIDTH = $clog2(N_BYTES);
  localparam int PW = $clog2(N_LINES);
  localparam int CW = $clog2(N_LINES + 1);
  logic [VA_WIDTH-1:0] addr_q [N_LINES];
  logic [REG_WIDTH-1:0] data_q [N_LINES];
  logic [N_BYTES-1:0] mask_q [N_LINES];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [OFF_WIDTH-1:0] off;
  logic [VA_WIDTH-1:0] word_addr;
  logic [N_BYTES-1:0] sz_mask, req_mask, fwd_mask, covered;
  logic [REG_WIDTH-1:0] fwd_data, lane_bits, st_data;
  logic misaligned, oversize, exc, full, pop, push, lookup, partial;
  assign off = i_addr[OFF_WIDTH-1:0];
  assign word_addr = {i_addr[VA_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
  assign sz_mask = i_size == 2'd0 ? N_BYTES'(1) : i_size == 2'd1 ? N_BYTES'(3) : N_BYTES'(15);
  assign req_mask = sz_mask << off;
  assign misaligned = |(i_addr & ((VA_WIDTH'(1) << i_size) - VA_WIDTH'(1)));
  assign oversize = (32'd1 << i_size) > 32'(N_BYTES);
  assign exc = (i_is_store | i_is_load) & (i_size == 2'd3 | misaligned | oversize | (i_is_store & i_is_load));
  assign full = count == CW'(N_LINES);
  assign o_empty = count == '0;
  assign o_commit_valid = !o_empty;
  assign pop = o_commit_valid & i_commit_ready;
  assign push = i_is_store & !exc & (!full | pop);
  assign lookup = i_is_load & !exc;
  // Walk oldest to youngest so younger covering entries overwrite older bytes
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    lane_bits = '0;
    for (int b = 0; b < N_BYTES; b++) lane_bits[8*b+:8] = {8{req_mask[b]}};
    for (int k = 0; k < N_LINES; k++) begin
      if (CW'(k) < count && addr_q[head + PW'(k)] == word_addr) begin
        fwd_mask = fwd_mask | mask_q[head + PW'(k)];
        for (int b = 0; b < N_BYTES; b++)
          if (mask_q[head + PW'(k)][b]) fwd_data[8*b+:8] = data_q[head + PW'(k)][8*b+:8];
      end
    end
  end
  assign covered = req_mask & fwd_mask;
  assign o_hit = lookup & (covered == req_mask);
  assign partial = lookup & (covered != '0) & (covered != req_mask);
  assign o_read_data = o_hit ? (fwd_data & lane_bits) >> {off, 3'b000} : '0;
  assign o_stall = (i_is_store & !exc & full & !pop) | partial;
  assign o_exeption = exc;
  assign st_data = (i_write_data << {off, 3'b000}) & lane_bits;
  assign o_commit_addr = o_commit_valid ? addr_q[head] : '0;
  assign o_commit_data = o_commit_valid ? data_q[head] : '0;
  assign o_commit_mask = o_commit_valid ? mask_q[head] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= word_addr;
        data_q[tail] <= st_data;
        mask_q[tail] <= req_mask;
        tail <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: randomized + directed stimulus against a byte-level queue model; a negedge monitor scores DUT outputs
module tb_store_queue;
  logic clk = 0, rst = 1;
  logic i_is_store = 0, i_is_load = 0, i_commit_ready = 0;
  logic [1:0] i_size = 0;
  logic [31:0] i_addr = 0, i_write_data = 0;
  logic o_hit, o_stall, o_exeption, o_commit_valid, o_empty;
  logic [31:0] o_read_data, o_commit_addr, o_commit_data;
  logic [3:0] o_commit_mask;

  store_queue #(.N_LINES(4), .VA_WIDTH(32), .REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_is_store(i_is_store), .i_is_load(i_is_load), .i_size(i_size),
    .i_addr(i_addr), .i_write_data(i_write_data), .o_hit(o_hit), .o_read_data(o_read_data),
    .o_stall(o_stall), .o_exeption(o_exeption), .o_commit_valid(o_commit_valid),
    .o_commit_addr(o_commit_addr), .o_commit_data(o_commit_data), .o_commit_mask(o_commit_mask),
    .i_commit_ready(i_commit_ready), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } ent_t;
  typedef struct { logic exc, hit, stall, empty, cvalid, idle, post_rst; logic [31:0] rdata; } resp_t;

  ent_t model[$];
  ent_t exp_c[$];
  resp_t resp_q[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One request cycle: predict the response from the model, then update the model
  task automatic cyc(input logic st, input logic ld, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy, input logic post_rst = 0);
    resp_t r;
    ent_t e;
    logic [3:0] got;
    logic [31:0] rd, sh;
    int nb, off, cnt;
    logic pop, push;
    i_is_store = st; i_is_load = ld; i_size = sz; i_addr = a; i_write_data = wd; i_commit_ready = rdy;
    nb = 1 << sz;
    off = int'(a % 4);
    r.exc = (st || ld) && (sz == 2'd3 || (a % nb) != 0 || (st && ld));
    got = 0;
    rd = 0;
    if (ld && !r.exc)
      for (int b = 0; b < nb; b++)
        for (int k = model.size() - 1; k >= 0; k--)
          if (model[k].addr == (a & ~32'h3) && model[k].mask[off + b]) begin
            rd[8*b+:8] = model[k].data[8*(off+b)+:8];
            got[b] = 1'b1;
            break;
          end
    cnt = $countones(got);
    r.hit = ld && !r.exc && cnt == nb;
    r.rdata = r.hit ? rd : 32'h0;
    pop = rdy && model.size() > 0;
    r.stall = (st && !r.exc && model.size() == 4 && !pop) || (ld && !r.exc && cnt > 0 && cnt < nb);
    r.empty = model.size() == 0;
    r.cvalid = !r.empty;
    r.idle = !st && !ld;
    r.post_rst = post_rst;
    resp_q.push_back(r);
    push = st && !r.exc && (model.size() < 4 || pop);
    if (pop) void'(model.pop_front());
    if (push) begin
      e.addr = a & ~32'h3;
      e.mask = 4'(((1 << nb) - 1) << off);
      sh = wd << (8 * off);
      for (int b = 0; b < 4; b++) e.data[8*b+:8] = e.mask[b] ? sh[8*b+:8] : 8'h0;
      model.push_back(e);
      exp_c.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    i_is_store = 0; i_is_load = 0; i_commit_ready = 0; i_size = 0; i_addr = 0; i_write_data = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model.delete();
    exp_c.delete();
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && model.size() > 0; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && resp_q.size() > 0) begin
      resp_t r;
      r = resp_q.pop_front();
      chk("exeption", 32'(o_exeption), 32'(r.exc));
      chk("hit", 32'(o_hit), 32'(r.hit));
      chk("stall", 32'(o_stall), 32'(r.stall));
      chk("empty", 32'(o_empty), 32'(r.empty));
      chk("commit_valid", 32'(o_commit_valid), 32'(r.cvalid));
      if (r.hit || r.idle) chk("read_data", o_read_data, r.rdata);
      if (r.post_rst) begin
        chk("rst_commit_addr", o_commit_addr, 32'h0);
        chk("rst_commit_data", o_commit_data, 32'h0);
        chk("rst_commit_mask", 32'(o_commit_mask), 32'h0);
      end
      if (r.cvalid) begin
        if (exp_c.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL commit_head: got valid head, expected no pending entry at %0t", $time);
        end else begin
          chk("commit_addr", o_commit_addr, exp_c[0].addr);
          chk("commit_data", o_commit_data, exp_c[0].data);
          chk("commit_mask", 32'(o_commit_mask), 32'(exp_c[0].mask));
          if (i_commit_ready) void'(exp_c.pop_front());
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0] sz;
    logic [31:0] a, wd;
    do_reset();
    // basic FIFO order and lane-aligned commit
    cyc(1, 0, 2, 32'h100, 32'h11223344, 0);
    cyc(1, 0, 0, 32'h105, 32'h000000AA, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // youngest-first forwarding
    cyc(1, 0, 2, 32'h200, 32'h11223344, 0);
    cyc(1, 0, 0, 32'h201, 32'h00000055, 0);
    cyc(0, 1, 1, 32'h200, 0, 0);
    cyc(0, 1, 2, 32'h200, 0, 0);
    cyc(0, 1, 0, 32'h203, 0, 0);
    drain();
    // partial hazard, then miss after drain
    cyc(1, 0, 0, 32'h300, 32'h00000077, 0);
    cyc(0, 1, 2, 32'h300, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 2, 32'h300, 0, 0);
    cyc(0, 1, 2, 32'h400, 0, 0);
    // full, stall, accept-with-pop, wrap
    for (int i = 0; i < 4; i++) cyc(1, 0, 2, 32'h500 + 4 * i, 32'hA0000000 + i, 0);
    cyc(1, 0, 2, 32'h510, 32'hA0000004, 0);
    cyc(1, 0, 2, 32'h510, 32'hA0000004, 1);
    cyc(1, 0, 1, 32'h512, 32'h0000BEEF, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 2, 32'h600 + 4 * i, 32'hB0000000 + i, 1);
    drain();
    // exceptions
    cyc(1, 0, 1, 32'h101, 32'h1234, 0);
    cyc(1, 0, 3, 32'h100, 32'h1234, 0);
    cyc(1, 1, 2, 32'h100, 32'h1234, 0);
    cyc(0, 1, 1, 32'h103, 0, 0);
    cyc(0, 1, 2, 32'h102, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // reset with pending entries
    for (int i = 0; i < 3; i++) cyc(1, 0, 2, 32'h700 + 4 * i, 32'hC0000000 + i, 0);
    do_reset();
    cyc(0, 1, 2, 32'h700, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // randomized traffic over a small address pool to force overlaps and hazards
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'h100 + 4 * $urandom_range(0, 3);
      if (sz != 2'd3 && $urandom_range(0, 4) != 0) a = a + ($urandom_range(0, 3) & ~((1 << sz) - 1));
      else a = a + $urandom_range(0, 3);
      wd = $urandom;
      if (sz == 2'd0) wd = wd & 32'hFF;
      if (sz == 2'd1) wd = wd & 32'hFFFF;
      cyc(r < 45 || (r >= 80 && r < 84), (r >= 45 && r < 84), sz, a, wd,
          ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    drain();
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("pending_commits", 32'(exp_c.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
